// File: rtl/npc_mc.sv
// Multi-cycle RV32I/RV32E subset core (lui/auipc/addi/jal/jalr/ebreak).
// Instructions are fetched over a valid/ready imem handshake; the core halts on ebreak or any fault.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_FETCH | request valid, address = pc, wait for imem_req_ready
//  S_WAIT  | request accepted, wait for imem_resp_valid, latch word
//  S_EXEC  | decode/execute latched word, write rd, update pc or halt
//  S_HALT  | terminal; no fetches or writes until rst
module npc_mc #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          NR_REGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pc,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] halt_pc,
    output logic [31:0] dbg_a0
);

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] INST_EBRK = 32'h00100073;

    localparam logic [1:0]  CAUSE_EBREAK  = 2'b01;
    localparam logic [1:0]  CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0]  CAUSE_MISALGN = 2'b11;

    localparam int IW = (NR_REGS > 16) ? 5 : 4;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_q;
    logic [31:0] inst;
    logic [31:0] regs [NR_REGS];
    logic        halted_q;
    logic [1:0]  cause_q;
    logic [31:0] halt_pc_q;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        rd_ok;
    logic        rs1_ok;
    logic [31:0] rs1_val;
    logic [31:0] pc_plus4;
    logic [31:0] jal_tgt;
    logic [31:0] jalr_tgt;

    logic        do_wr;
    logic [31:0] wr_val;
    logic [31:0] pc_nx;
    logic        do_halt;
    logic [1:0]  cause_nx;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    // Register indices beyond the implemented file (RV32E) make the instruction illegal.
    assign rd_ok  = (NR_REGS >= 32) || ({1'b0, rd}  < 6'(NR_REGS));
    assign rs1_ok = (NR_REGS >= 32) || ({1'b0, rs1} < 6'(NR_REGS));

    assign rs1_val  = (rs1 == 5'd0 || !rs1_ok) ? 32'd0 : regs[rs1[IW-1:0]];
    assign pc_plus4 = pc_q + 32'd4;
    assign jal_tgt  = pc_q + imm_j;
    assign jalr_tgt = (rs1_val + imm_i) & ~32'd1;

    always_comb begin
        do_wr    = 1'b0;
        wr_val   = 32'd0;
        pc_nx    = pc_plus4;
        do_halt  = 1'b0;
        cause_nx = 2'b00;
        case (opcode)
            OP_LUI: begin
                if (rd_ok) begin
                    do_wr  = 1'b1;
                    wr_val = imm_u;
                end else begin
                    do_halt  = 1'b1;
                    cause_nx = CAUSE_ILLEGAL;
                end
            end
            OP_AUIPC: begin
                if (rd_ok) begin
                    do_wr  = 1'b1;
                    wr_val = pc_q + imm_u;
                end else begin
                    do_halt  = 1'b1;
                    cause_nx = CAUSE_ILLEGAL;
                end
            end
            OP_IMM: begin
                if (funct3 == 3'b000 && rd_ok && rs1_ok) begin
                    do_wr  = 1'b1;
                    wr_val = rs1_val + imm_i;
                end else begin
                    do_halt  = 1'b1;
                    cause_nx = CAUSE_ILLEGAL;
                end
            end
            OP_JAL: begin
                if (!rd_ok) begin
                    do_halt  = 1'b1;
                    cause_nx = CAUSE_ILLEGAL;
                end else if (jal_tgt[1]) begin
                    do_halt  = 1'b1;
                    cause_nx = CAUSE_MISALGN;
                end else begin
                    do_wr  = 1'b1;
                    wr_val = pc_plus4;
                    pc_nx  = jal_tgt;
                end
            end
            OP_JALR: begin
                if (funct3 != 3'b000 || !rd_ok || !rs1_ok) begin
                    do_halt  = 1'b1;
                    cause_nx = CAUSE_ILLEGAL;
                end else if (jalr_tgt[1]) begin
                    do_halt  = 1'b1;
                    cause_nx = CAUSE_MISALGN;
                end else begin
                    do_wr  = 1'b1;
                    wr_val = pc_plus4;
                    pc_nx  = jalr_tgt;
                end
            end
            default: begin
                do_halt  = 1'b1;
                cause_nx = (inst == INST_EBRK) ? CAUSE_EBREAK : CAUSE_ILLEGAL;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: if (imem_req_ready)  state_nx = S_WAIT;
            S_WAIT:  if (imem_resp_valid) state_nx = S_EXEC;
            S_EXEC:  state_nx = do_halt ? S_HALT : S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc_q      <= RESET_PC;
            inst      <= 32'd0;
            halted_q  <= 1'b0;
            cause_q   <= 2'b00;
            halt_pc_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT && imem_resp_valid) begin
                inst <= imem_resp_data;
            end
            if (state == S_EXEC) begin
                if (do_halt) begin
                    halted_q  <= 1'b1;
                    cause_q   <= cause_nx;
                    halt_pc_q <= pc_q;
                end else begin
                    pc_q <= pc_nx;
                end
            end
        end
    end

    // x0 is never written, so its slot stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_en) begin
            regs[rd[IW-1:0]] <= wr_val;
        end
    end

    assign imem_req_valid = (state == S_FETCH) && !rst;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign wb_en          = (state == S_EXEC) && do_wr && (rd != 5'd0) && !rst;
    assign wb_addr        = rd;
    assign wb_data        = wr_val;
    assign halted         = halted_q;
    assign halt_cause     = cause_q;
    assign halt_pc        = halt_pc_q;
    assign dbg_a0         = regs[IW'(10)];

endmodule

// File: tb/tb_npc_mc.sv
// Bench for npc_mc: imem model with programmable ready/response delays and a commit scoreboard.
// A second RV32E instance runs a fixed one-word program to exercise the register-range check.
module tb_npc_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] halt_pc;
    logic [31:0] dbg_a0;

    logic        e_req_valid;
    logic        e_req_ready = 1'b0;
    logic [31:0] e_addr;
    logic        e_resp_valid = 1'b0;
    logic [31:0] e_resp_data = 32'd0;
    logic [31:0] e_pc;
    logic        e_wb_en;
    logic [4:0]  e_wb_addr;
    logic [31:0] e_wb_data;
    logic        e_halted;
    logic [1:0]  e_halt_cause;
    logic [31:0] e_halt_pc;
    logic [31:0] e_dbg_a0;

    always #5 clk = ~clk;

    npc_mc #(.RESET_PC(32'h80000000), .NR_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .halted(halted), .halt_cause(halt_cause), .halt_pc(halt_pc), .dbg_a0(dbg_a0)
    );

    npc_mc #(.RESET_PC(32'h80000000), .NR_REGS(16)) dut_e (
        .clk(clk), .rst(rst),
        .imem_req_valid(e_req_valid), .imem_req_ready(e_req_ready), .imem_addr(e_addr),
        .imem_resp_valid(e_resp_valid), .imem_resp_data(e_resp_data),
        .pc(e_pc), .wb_en(e_wb_en), .wb_addr(e_wb_addr), .wb_data(e_wb_data),
        .halted(e_halted), .halt_cause(e_halt_cause), .halt_pc(e_halt_pc), .dbg_a0(e_dbg_a0)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } commit_t;

    commit_t     exp_q[$];
    commit_t     obs_q[$];
    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ready_delay = 0;
    int          resp_delay = 0;
    int          acc_cnt = 0;
    int          addr_chg = 0;
    int          req_in_wait = 0;
    int          e_wb_cnt = 0;
    logic [31:0] first_acc_addr = 32'd0;

    logic        pend = 1'b0;
    int          pcnt = 0;
    int          rcnt = 0;
    logic [31:0] paddr = 32'd0;
    logic        prev_rv = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic        acc;

    localparam logic [31:0] EBRK = 32'h00100073;
    localparam logic [31:0] BASE = 32'h80000000;

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_auipc(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0010111};
    endfunction
    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [7:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return off[7:0];
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wb_en === 1'b1) obs_q.push_back('{cyc: cyc, a: wb_addr, d: wb_data});
        if (e_wb_en === 1'b1) e_wb_cnt++;
    end

    // Main imem: ready after ready_delay requesting cycles, response resp_delay cycles after acceptance.
    always @(negedge clk) begin
        if (rst) begin
            imem_req_ready  = 1'b0;
            imem_resp_valid = 1'b0;
            pend = 1'b0;
            rcnt = 0;
            prev_rv = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            if (imem_req_valid && prev_rv && !prev_rdy && imem_addr !== prev_addr) addr_chg++;
            prev_rv = imem_req_valid;
            prev_rdy = imem_req_ready;
            prev_addr = imem_addr;
            acc = 1'b0;
            if (imem_req_ready) begin
                imem_req_ready = 1'b0;
                if (acc_cnt == 0) first_acc_addr = paddr;
                acc_cnt++;
                pend = 1'b1;
                pcnt = resp_delay;
                acc = 1'b1;
            end
            if (pend && imem_req_valid) req_in_wait++;
            if (pend) begin
                if (pcnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem[widx(paddr)];
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end else if (!acc && imem_req_valid) begin
                if (rcnt >= ready_delay) begin
                    imem_req_ready = 1'b1;
                    paddr = imem_addr;
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end
        end
    end

    // RV32E imem: zero-wait, every word is addi x16,x0,1.
    always @(negedge clk) begin
        if (rst) begin
            e_req_ready  = 1'b0;
            e_resp_valid = 1'b0;
        end else begin
            e_resp_valid = 1'b0;
            if (e_req_ready) begin
                e_req_ready  = 1'b0;
                e_resp_valid = 1'b1;
                e_resp_data  = enc_addi(5'd16, 5'd0, 12'd1);
            end else if (e_req_valid) begin
                e_req_ready = 1'b1;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        exp_q.delete();
        obs_q.delete();
        acc_cnt = 0;
        addr_chg = 0;
        req_in_wait = 0;
        e_wb_cnt = 0;
        #2 rst = 1'b0;
    endtask

    task automatic run_until_halt(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
        end
        tests++;
        if (halted !== 1'b1) begin
            fails++;
            $display("FAIL %s halt_timeout: halted=%b after %0d cycles, required 1", name, halted, budget);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (imem_req_valid !== 1'b0 || e_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_req_valid: got %b/%b, required 0/0", imem_req_valid, e_req_valid);
        end
        tests++;
        if (pc !== BASE || halted !== 1'b0 || halt_cause !== 2'b00 || halt_pc !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: pc=%h halted=%b cause=%b halt_pc=%h, required 80000000/0/00/00000000",
                     pc, halted, halt_cause, halt_pc);
        end
        tests++;
        if (wb_en !== 1'b0 || dbg_a0 !== 32'd0) begin
            fails++;
            $display("FAIL reset_wb: wb_en=%b dbg_a0=%h, required 0/00000000", wb_en, dbg_a0);
        end
        @(negedge clk);
        tests++;
        if (imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_req_valid_2: got %b, required 0", imem_req_valid);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        run_until_halt(50, "reset");
        tests++;
        if (acc_cnt != 1 || first_acc_addr !== BASE) begin
            fails++;
            $display("FAIL first_fetch: count=%0d addr=%h, required 1/80000000", acc_cnt, first_acc_addr);
        end
        tests++;
        if (halt_cause !== 2'b10 || halt_pc !== BASE) begin
            fails++;
            $display("FAIL zero_word_illegal: cause=%b halt_pc=%h, required 10/80000000", halt_cause, halt_pc);
        end
    endtask

    task automatic test_addi_lui_auipc();
        commit_t e, o;
        clear_mem();
        mem[0] = enc_addi(5'd1, 5'd0, 12'd5);
        mem[1] = enc_addi(5'd1, 5'd1, 12'hFFA);
        mem[2] = enc_auipc(5'd3, 20'h00001);
        mem[3] = enc_lui(5'd2, 20'h12345);
        mem[4] = EBRK;
        do_reset();
        exp_q.push_back('{cyc: 0, a: 5'd1, d: 32'h00000005});
        exp_q.push_back('{cyc: 0, a: 5'd1, d: 32'hFFFFFFFF});
        exp_q.push_back('{cyc: 0, a: 5'd3, d: 32'h80001008});
        exp_q.push_back('{cyc: 0, a: 5'd2, d: 32'h12345000});
        run_until_halt(100, "addi");
        tests++;
        if (obs_q.size() < 2 || obs_q[1].cyc - obs_q[0].cyc != 3) begin
            fails++;
            $display("FAIL addi_spacing: %0d commits, gap=%0d, required gap 3", obs_q.size(),
                     (obs_q.size() >= 2) ? obs_q[1].cyc - obs_q[0].cyc : -1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL addi_commit: commit missing, required x%0d=%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.d !== e.d) begin
                    fails++;
                    $display("FAIL addi_commit: got x%0d=%h, required x%0d=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0 || halt_cause !== 2'b01 || halt_pc !== 32'h80000010) begin
            fails++;
            $display("FAIL addi_halt: extra=%0d cause=%b halt_pc=%h, required 0/01/80000010",
                     obs_q.size(), halt_cause, halt_pc);
        end
    endtask

    task automatic test_jal_jalr();
        commit_t e, o;
        clear_mem();
        mem[0] = enc_jal(5'd1, 21'd8);
        mem[2] = enc_addi(5'd0, 5'd0, 12'd9);
        mem[3] = enc_jalr(5'd1, 5'd1, 12'h010);
        mem[5] = enc_addi(5'd10, 5'd0, 12'd7);
        mem[6] = EBRK;
        do_reset();
        exp_q.push_back('{cyc: 0, a: 5'd1,  d: 32'h80000004});
        exp_q.push_back('{cyc: 0, a: 5'd1,  d: 32'h80000010});
        exp_q.push_back('{cyc: 0, a: 5'd10, d: 32'h00000007});
        run_until_halt(100, "jal");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL jal_commit: commit missing, required x%0d=%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.d !== e.d) begin
                    fails++;
                    $display("FAIL jal_commit: got x%0d=%h, required x%0d=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0 || halt_cause !== 2'b01 || halt_pc !== 32'h80000018 || dbg_a0 !== 32'd7) begin
            fails++;
            $display("FAIL jal_halt: extra=%0d cause=%b halt_pc=%h a0=%h, required 0/01/80000018/00000007",
                     obs_q.size(), halt_cause, halt_pc, dbg_a0);
        end
    endtask

    task automatic test_misaligned();
        commit_t e, o;
        clear_mem();
        mem[0] = enc_lui(5'd5, 20'h80000);
        mem[1] = enc_addi(5'd5, 5'd5, 12'h100);
        mem[2] = enc_jalr(5'd1, 5'd5, 12'd3);
        do_reset();
        exp_q.push_back('{cyc: 0, a: 5'd5, d: 32'h80000000});
        exp_q.push_back('{cyc: 0, a: 5'd5, d: 32'h80000100});
        run_until_halt(100, "misaligned");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL mis_commit: commit missing, required x%0d=%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.d !== e.d) begin
                    fails++;
                    $display("FAIL mis_commit: got x%0d=%h, required x%0d=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0 || halt_cause !== 2'b11 || halt_pc !== 32'h80000008 || pc !== 32'h80000008) begin
            fails++;
            $display("FAIL mis_halt: extra=%0d cause=%b halt_pc=%h pc=%h, required 0/11/80000008/80000008",
                     obs_q.size(), halt_cause, halt_pc, pc);
        end
    endtask

    task automatic test_stall();
        commit_t e, o;
        clear_mem();
        mem[0] = enc_addi(5'd4, 5'd0, 12'h055);
        mem[1] = EBRK;
        ready_delay = 4;
        resp_delay = 3;
        do_reset();
        exp_q.push_back('{cyc: 0, a: 5'd4, d: 32'h00000055});
        run_until_halt(200, "stall");
        tests++;
        if (acc_cnt != 2 || addr_chg != 0 || req_in_wait != 0) begin
            fails++;
            $display("FAIL stall_handshake: fetches=%0d addr_changes=%0d req_in_wait=%0d, required 2/0/0",
                     acc_cnt, addr_chg, req_in_wait);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL stall_commit: commit missing, required x%0d=%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.d !== e.d) begin
                    fails++;
                    $display("FAIL stall_commit: got x%0d=%h, required x%0d=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0 || halt_cause !== 2'b01 || halt_pc !== 32'h80000004) begin
            fails++;
            $display("FAIL stall_halt: extra=%0d cause=%b halt_pc=%h, required 0/01/80000004",
                     obs_q.size(), halt_cause, halt_pc);
        end
        ready_delay = 0;
        resp_delay = 0;
    endtask

    task automatic test_ebreak_hold();
        logic        bad;
        logic [31:0] pc_frozen;
        clear_mem();
        mem[0] = enc_addi(5'd10, 5'd0, 12'd3);
        mem[1] = enc_addi(5'd10, 5'd0, 12'd0);
        mem[2] = EBRK;
        do_reset();
        tests++;
        if (dbg_a0 !== 32'd0) begin
            fails++;
            $display("FAIL reset_clears_gpr: dbg_a0=%h, required 00000000", dbg_a0);
        end
        run_until_halt(100, "ebreak");
        tests++;
        if (halt_cause !== 2'b01 || halt_pc !== 32'h80000008 || dbg_a0 !== 32'd0 || obs_q.size() != 2) begin
            fails++;
            $display("FAIL ebreak_halt: cause=%b halt_pc=%h a0=%h commits=%0d, required 01/80000008/00000000/2",
                     halt_cause, halt_pc, dbg_a0, obs_q.size());
        end
        pc_frozen = pc;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req_valid !== 1'b0 || wb_en !== 1'b0 || pc !== pc_frozen || halted !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL halt_sticky: activity in HALT (req=%b wb=%b pc=%h), required idle at %h",
                     imem_req_valid, wb_en, pc, pc_frozen);
        end
    endtask

    task automatic test_rv32e();
        clear_mem();
        mem[0] = EBRK;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (e_halted === 1'b1) break;
        end
        tests++;
        if (e_halted !== 1'b1 || e_halt_cause !== 2'b10 || e_halt_pc !== BASE || e_wb_cnt != 0) begin
            fails++;
            $display("FAIL rv32e_x16: halted=%b cause=%b halt_pc=%h writes=%0d, required 1/10/80000000/0",
                     e_halted, e_halt_cause, e_halt_pc, e_wb_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_addi_lui_auipc();
        test_jal_jalr();
        test_misaligned();
        test_stall();
        test_ebreak_hold();
        test_rv32e();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
